// File: rtl/bus_arbiter_2m.sv
// Two-master front end for the shared 64-bit slave bus: round-robin arbitration with
// a bounded hold time, owner-selected write/address path and read-data steering.
module bus_arbiter_2m #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_address,
  input  logic [15:0] m1_address,
  input  logic [63:0] m0_dout,
  input  logic [63:0] m1_dout,
  input  logic [63:0] bus_din,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [63:0] m0_din,
  output logic [63:0] m1_din,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [15:0] bus_address,
  output logic [63:0] bus_dout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_owner;
  logic [7:0]  r_hold_cnt;
  logic [1:0]  r_rd_owner;
  logic        w_hold_done;
  logic        w_state_chg;

  assign w_hold_done = (r_hold_cnt == HOLD_LAST);
  assign w_state_chg = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) w_state_nxt = r_last_owner ? GNT0 : GNT1;
        else if (m0_req)      w_state_nxt = GNT0;
        else if (m1_req)      w_state_nxt = GNT1;
        else                  w_state_nxt = IDLE;
      end
      GNT0: begin
        if (!m0_req)                  w_state_nxt = m1_req ? GNT1 : IDLE;
        else if (m1_req && w_hold_done) w_state_nxt = GNT1;
        else                          w_state_nxt = GNT0;
      end
      GNT1: begin
        if (!m1_req)                  w_state_nxt = m0_req ? GNT0 : IDLE;
        else if (m0_req && w_hold_done) w_state_nxt = GNT0;
        else                          w_state_nxt = GNT1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_hold_cnt   <= 8'd0;
      r_rd_owner   <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_owner <= {m0_grant, m1_grant};
      if (w_state_chg || (w_state_nxt == IDLE)) begin
        r_hold_cnt <= 8'd0;
      end else if (!w_hold_done) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
      if (w_state_chg && (w_state_nxt == GNT0)) r_last_owner <= 1'b0;
      if (w_state_chg && (w_state_nxt == GNT1)) r_last_owner <= 1'b1;
    end
  end

  assign m0_grant = (r_state == GNT0);
  assign m1_grant = (r_state == GNT1);
  assign bus_req  = m0_grant | m1_grant;

  always_comb begin
    bus_wr      = 1'b0;
    bus_address = 16'h0000;
    bus_dout    = 64'h0;
    if (m0_grant) begin
      bus_wr      = m0_wr;
      bus_address = m0_address;
      bus_dout    = m0_dout;
    end else if (m1_grant) begin
      bus_wr      = m1_wr;
      bus_address = m1_address;
      bus_dout    = m1_dout;
    end
  end

  // Read data lags the address phase by one cycle, so steer by last cycle's owner.
  assign m0_din = (r_rd_owner == 2'b10) ? bus_din : 64'h0;
  assign m1_din = (r_rd_owner == 2'b01) ? bus_din : 64'h0;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Self-checking bench for bus_arbiter_2m: directed vector table, hand sequences for
// preemption / hold / async reset, and randomized traffic against a cycle model.
module tb_bus_arbiter_2m;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_wr = 1'b0, m1_wr = 1'b0;
  logic [15:0] m0_address = '0, m1_address = '0;
  logic [63:0] m0_dout = '0, m1_dout = '0;
  logic [63:0] bus_din = '0;
  logic        m0_grant, m1_grant, bus_req, bus_wr;
  logic [63:0] m0_din, m1_din, bus_dout;
  logic [15:0] bus_address;

  int checks = 0;
  int errors = 0;

  bus_arbiter_2m #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_address(m0_address), .m1_address(m1_address),
    .m0_dout(m0_dout), .m1_dout(m1_dout), .bus_din(bus_din),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m0_din(m0_din), .m1_din(m1_din),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_address(bus_address), .bus_dout(bus_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, w0;
    logic [15:0] a0, a1;
    logic [63:0] d0, d1, bin;
    logic        g0, g1, ewr;
    logic [15:0] eaddr;
    logic [63:0] edout, em0, em1;
  } vec_t;

  vec_t tbl[7];

  // Behavioural model: owner -1/0/1, cycles held so far, previous owner for read return
  int mdl_owner, mdl_last, mdl_held, mdl_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic g0, input logic g1, input logic wr,
                         input logic [15:0] addr, input logic [63:0] dout,
                         input logic [63:0] em0, input logic [63:0] em1);
    chk({tag, ".m0_grant"}, 64'(m0_grant), 64'(g0));
    chk({tag, ".m1_grant"}, 64'(m1_grant), 64'(g1));
    chk({tag, ".bus_req"}, 64'(bus_req), 64'(g0 | g1));
    chk({tag, ".bus_wr"}, 64'(bus_wr), 64'(wr));
    chk({tag, ".bus_address"}, 64'(bus_address), 64'(addr));
    chk({tag, ".bus_dout"}, bus_dout, dout);
    chk({tag, ".m0_din"}, m0_din, em0);
    chk({tag, ".m1_din"}, m1_din, em1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
    m0_address = '0; m1_address = '0; m0_dout = '0; m1_dout = '0; bus_din = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic model_reset();
    mdl_owner = -1; mdl_last = 1; mdl_held = 0; mdl_rd = -1;
  endtask

  task automatic model_edge(input logic q0, input logic q1);
    int req[2];
    int nxt;
    req[0] = int'(q0);
    req[1] = int'(q1);
    mdl_rd = mdl_owner;
    if (mdl_owner < 0) begin
      if (req[0] == 1 && req[1] == 1) nxt = 1 - mdl_last;
      else if (req[0] == 1)           nxt = 0;
      else if (req[1] == 1)           nxt = 1;
      else                            nxt = -1;
    end else if (req[mdl_owner] == 0) begin
      nxt = (req[1 - mdl_owner] == 1) ? 1 - mdl_owner : -1;
    end else if (req[1 - mdl_owner] == 1 && mdl_held >= MAX_HOLD) begin
      nxt = 1 - mdl_owner;
    end else begin
      nxt = mdl_owner;
    end
    if (nxt != mdl_owner) begin
      mdl_held = (nxt < 0) ? 0 : 1;
      if (nxt >= 0) mdl_last = nxt;
    end else if (nxt >= 0 && mdl_held < MAX_HOLD) begin
      mdl_held++;
    end
    mdl_owner = nxt;
  endtask

  initial begin
    //          r0 r1 w0  a0        a1        d0                     d1          bin          g0 g1 wr eaddr     edout                  em0          em1
    tbl[0] = '{1, 0, 0, 16'h0005, 16'h0102, 64'h0,                 64'hF0F0, 64'h0,       1, 0, 0, 16'h0005, 64'h0,                 64'h0,       64'h0};
    tbl[1] = '{1, 0, 1, 16'h0010, 16'h0102, 64'hDEADBEEF00000001, 64'hF0F0, 64'h55,      1, 0, 1, 16'h0010, 64'hDEADBEEF00000001, 64'h55,      64'h0};
    tbl[2] = '{0, 1, 0, 16'h0010, 16'h0102, 64'h0,                 64'hF0F0, 64'h77,      0, 1, 0, 16'h0102, 64'hF0F0,              64'h77,      64'h0};
    tbl[3] = '{1, 1, 0, 16'h0010, 16'h0102, 64'h0,                 64'hF0F0, 64'h1234,    0, 1, 0, 16'h0102, 64'hF0F0,              64'h0,       64'h1234};
    tbl[4] = '{1, 0, 1, 16'h0020, 16'h0102, 64'h0ABC,              64'hF0F0, 64'hABCD,    1, 0, 1, 16'h0020, 64'h0ABC,              64'h0,       64'hABCD};
    tbl[5] = '{0, 0, 0, 16'h0020, 16'h0102, 64'h0ABC,              64'hF0F0, 64'h99,      0, 0, 0, 16'h0000, 64'h0,                 64'h99,      64'h0};
    tbl[6] = '{0, 0, 0, 16'h0020, 16'h0102, 64'h0ABC,              64'hF0F0, 64'h42,      0, 0, 0, 16'h0000, 64'h0,                 64'h0,       64'h0};

    // Reset state with busy-looking inputs
    reset_n = 0;
    m0_req = 1; m1_req = 1; m0_wr = 1; m0_address = 16'h1234; m0_dout = 64'h1111;
    bus_din = 64'hFFFF_FFFF;
    step();
    chk_out("reset", 0, 0, 0, 16'h0, 64'h0, 64'h0, 64'h0);
    idle_inputs();
    reset_n = 1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      m0_req = tbl[i].r0; m1_req = tbl[i].r1; m0_wr = tbl[i].w0; m1_wr = 0;
      m0_address = tbl[i].a0; m1_address = tbl[i].a1;
      m0_dout = tbl[i].d0; m1_dout = tbl[i].d1; bus_din = tbl[i].bin;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].ewr, tbl[i].eaddr,
              tbl[i].edout, tbl[i].em0, tbl[i].em1);
    end

    // Both requesting from reset: 8 cycles each, master 0 first
    do_reset();
    m0_req = 1; m1_req = 1; m0_address = 16'h00A0; m1_address = 16'h00B1;
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      int own;
      step();
      own = (i / MAX_HOLD) % 2;
      chk($sformatf("preempt%0d.m0_grant", i), 64'(m0_grant), 64'(own == 0));
      chk($sformatf("preempt%0d.m1_grant", i), 64'(m1_grant), 64'(own == 1));
      chk($sformatf("preempt%0d.bus_address", i), 64'(bus_address),
          (own == 0) ? 64'h00A0 : 64'h00B1);
    end

    // Master 1 alone holds indefinitely
    do_reset();
    m1_req = 1; m1_address = 16'h0C0C;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("hold%0d.m1_grant", i), 64'(m1_grant), 64'h1);
      chk($sformatf("hold%0d.m0_grant", i), 64'(m0_grant), 64'h0);
    end

    // Asynchronous reset mid-GNT1 clears everything before the next edge
    m1_wr = 1; m1_dout = 64'h5A5A; bus_din = 64'h7777;
    #2;
    reset_n = 0;
    #1;
    chk_out("async_rst", 0, 0, 0, 16'h0, 64'h0, 64'h0, 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1;
    m0_req = 1; m1_req = 1;
    step();
    chk("post_rst.m0_grant", 64'(m0_grant), 64'h1);
    chk("post_rst.m1_grant", 64'(m1_grant), 64'h0);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic eg0, eg1, ewr;
      logic [15:0] ea;
      logic [63:0] ed, e0, e1;
      if ($urandom_range(7) == 0) m0_req = ~m0_req;
      if ($urandom_range(7) == 0) m1_req = ~m1_req;
      m0_wr = 1'($urandom); m1_wr = 1'($urandom);
      m0_address = 16'($urandom); m1_address = 16'($urandom);
      m0_dout = {$urandom, $urandom}; m1_dout = {$urandom, $urandom};
      bus_din = {$urandom, $urandom};
      model_edge(m0_req, m1_req);
      step();
      eg0 = (mdl_owner == 0);
      eg1 = (mdl_owner == 1);
      ewr = eg0 ? m0_wr : (eg1 ? m1_wr : 1'b0);
      ea  = eg0 ? m0_address : (eg1 ? m1_address : 16'h0);
      ed  = eg0 ? m0_dout : (eg1 ? m1_dout : 64'h0);
      e0  = (mdl_rd == 0) ? bus_din : 64'h0;
      e1  = (mdl_rd == 1) ? bus_din : 64'h0;
      chk_out($sformatf("rand%0d", i), eg0, eg1, ewr, ea, ed, e0, e1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
